// File: rtl/led_scan_decoder_pkg.sv
// Shared tables and types for the multiplexed LED scan decoder.
// Select codes, 7-segment glyphs, mode triples and FSM states.
package led_scan_decoder_pkg;

   typedef enum logic {
      HUNT,
      COLLECT
   } state_t;

   localparam int NDIG   = 8;
   localparam int NGLYPH = 14;
   localparam int NMODE  = 8;

   // active-low one-hot digit selects, index 0..7
   localparam logic [7:0] SEL_CODE [NDIG] = '{
      8'hFE, 8'hFD, 8'hFB, 8'hF7,
      8'hEF, 8'hDF, 8'hBF, 8'h7F
   };

   // active-low segments g..a and the nibble each glyph shows
   localparam logic [6:0] GLYPH_SEG [NGLYPH] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
      7'h08, 7'h46, 7'h06, 7'h0E
   };

   localparam logic [3:0] GLYPH_VAL [NGLYPH] = '{
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
      4'h5, 4'h6, 4'h7, 4'h8, 4'h9,
      4'hA, 4'hC, 4'hE, 4'hF
   };

   // {digit7, digit6, digit5}; table position is the mode code
   localparam logic [11:0] MODE_TRIPLE [NMODE] = '{
      12'h180, 12'h261, 12'h330, 12'h396,
      12'h524, 12'h618, 12'h743, 12'h850
   };

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational 7-segment glyph decode.
// Unknown glyphs flag an error and decode to nibble 0.
module seg7_glyph_decode
   import led_scan_decoder_pkg::*;
(
   input  logic [7:0] seg,
   output logic [3:0] nibble,
   output logic       dp,
   output logic       err
);

   // match segments[6:0] against the glyph table
   always_comb begin
      nibble = 4'h0;
      err    = 1'b1;
      for (int i = 0; i < NGLYPH; i++) begin
         if (seg[6:0] == GLYPH_SEG[i]) begin
            nibble = GLYPH_VAL[i];
            err    = 1'b0;
         end
      end
   end

   assign dp = ~seg[7];

endmodule

// File: rtl/led_scan_decoder.sv
// Reassembles a hex value and mode code from a scanned LED bus.
// Frames run digit 0..7 and commit on the wrap back to digit 0.
module led_scan_decoder
   import led_scan_decoder_pkg::*;
(
   input  logic        clk_fs,
   input  logic        rst_n,
   input  logic        scan_en,
   input  logic [15:0] scan_in,
   output logic [19:0] value_out,
   output logic        value_valid,
   output logic [7:0]  dp_out,
   output logic [2:0]  sw_code,
   output logic        sw_err,
   output logic        frame_err,
   output logic        locked
);

   state_t      state;
   logic [2:0]  prev;
   logic [3:0]  dig [NDIG];
   logic [7:0]  dps;
   logic        flag;

   logic [2:0]  idx;
   logic        sel_ok;
   logic [3:0]  g_nib;
   logic        g_dp;
   logic        g_err;
   logic [2:0]  mode_code;
   logic        mode_ok;
   logic [11:0] triple;
   logic        rep;
   logic        nxt;
   logic        wrap;

   seg7_glyph_decode u_glyph (
      .seg    (scan_in[7:0]),
      .nibble (g_nib),
      .dp     (g_dp),
      .err    (g_err)
   );

   // digit select to index
   always_comb begin
      idx    = 3'd0;
      sel_ok = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (scan_in[15:8] == SEL_CODE[i]) begin
            idx    = 3'(i);
            sel_ok = 1'b1;
         end
      end
   end

   // mode lookup on the stored digits 5..7
   always_comb begin
      triple    = {dig[7], dig[6], dig[5]};
      mode_code = 3'd0;
      mode_ok   = 1'b0;
      for (int i = 0; i < NMODE; i++) begin
         if (dps[7] && !dps[6] && !dps[5] &&
             triple == MODE_TRIPLE[i]) begin
            mode_code = 3'(i);
            mode_ok   = 1'b1;
         end
      end
   end

   assign rep  = sel_ok && (idx == prev);
   assign nxt  = sel_ok && (prev != 3'd7) &&
                 (idx == prev + 3'd1);
   assign wrap = sel_ok && (idx == 3'd0) &&
                 (prev == 3'd7);

   assign locked = (state == COLLECT);

   // frame tracking FSM with registered commit outputs
   always_ff @(posedge clk_fs or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HUNT;
         prev        <= 3'd0;
         dps         <= 8'h00;
         flag        <= 1'b0;
         value_out   <= 20'h0;
         value_valid <= 1'b0;
         dp_out      <= 8'h00;
         sw_code     <= 3'd0;
         sw_err      <= 1'b0;
         frame_err   <= 1'b0;
         for (int i = 0; i < NDIG; i++)
            dig[i] <= 4'h0;
      end else begin
         value_valid <= 1'b0;
         frame_err   <= 1'b0;
         if (scan_en) begin
            unique case (state)
               HUNT: begin
                  if (sel_ok && idx == 3'd0) begin
                     dig[0] <= g_nib;
                     dps[0] <= g_dp;
                     flag   <= g_err;
                     prev   <= 3'd0;
                     state  <= COLLECT;
                  end
               end
               COLLECT: begin
                  unique case (1'b1)
                     rep, nxt: begin
                        dig[idx] <= g_nib;
                        dps[idx] <= g_dp;
                        flag     <= flag | g_err;
                        prev     <= idx;
                     end
                     wrap: begin
                        if (flag) begin
                           frame_err <= 1'b1;
                        end else begin
                           value_valid <= 1'b1;
                           value_out   <= {dig[4], dig[3],
                                           dig[2], dig[1],
                                           dig[0]};
                           dp_out      <= dps;
                           if (mode_ok) begin
                              sw_code <= mode_code;
                              sw_err  <= 1'b0;
                           end else begin
                              sw_err  <= 1'b1;
                           end
                        end
                        dig[0] <= g_nib;
                        dps[0] <= g_dp;
                        flag   <= g_err;
                        prev   <= 3'd0;
                     end
                     default: begin
                        frame_err <= 1'b1;
                        state     <= HUNT;
                     end
                  endcase
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_scan_decoder.sv
// Directed bench for led_scan_decoder.
// Drives scan frames and checks commits, errors and reset.
module tb_led_scan_decoder;

   logic        clk_fs;
   logic        rst_n;
   logic        scan_en;
   logic [15:0] scan_in;
   logic [19:0] value_out;
   logic        value_valid;
   logic [7:0]  dp_out;
   logic [2:0]  sw_code;
   logic        sw_err;
   logic        frame_err;
   logic        locked;

   int n_chk = 0;
   int n_err = 0;
   int vv    = 0;
   int fe    = 0;
   int bad_idx = -1;

   led_scan_decoder dut (
      .clk_fs      (clk_fs),
      .rst_n       (rst_n),
      .scan_en     (scan_en),
      .scan_in     (scan_in),
      .value_out   (value_out),
      .value_valid (value_valid),
      .dp_out      (dp_out),
      .sw_code     (sw_code),
      .sw_err      (sw_err),
      .frame_err   (frame_err),
      .locked      (locked)
   );

   initial clk_fs = 1'b0;
   always #5 clk_fs = ~clk_fs;

   function automatic logic [6:0] gl(input logic [3:0] n);
      case (n)
         4'h0: gl = 7'h40;
         4'h1: gl = 7'h79;
         4'h2: gl = 7'h24;
         4'h3: gl = 7'h30;
         4'h4: gl = 7'h19;
         4'h5: gl = 7'h12;
         4'h6: gl = 7'h02;
         4'h7: gl = 7'h78;
         4'h8: gl = 7'h00;
         4'h9: gl = 7'h10;
         4'hA: gl = 7'h08;
         4'hC: gl = 7'h46;
         4'hE: gl = 7'h06;
         4'hF: gl = 7'h0E;
         default: gl = 7'h7F;
      endcase
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic send(input int k,
                       input logic [3:0] n,
                       input logic dp);
      logic [7:0] s;
      logic [7:0] g;
      s = 8'h01 << k;
      g = (bad_idx == k) ? 8'hFF : {~dp, gl(n)};
      @(negedge clk_fs);
      scan_in = {~s, g};
      scan_en = 1'b1;
      @(posedge clk_fs);
      #1;
      scan_en = 1'b0;
      if (value_valid === 1'b1) vv++;
      if (frame_err === 1'b1) fe++;
   endtask

   task automatic send_frame(input logic [19:0] v,
                             input logic [3:0] d5,
                             input logic [3:0] d6,
                             input logic [3:0] d7,
                             input bit dbl);
      send(0, v[3:0], 1'b0);
      if (dbl) send(0, v[3:0], 1'b0);
      for (int k = 1; k < 5; k++)
         send(k, v[4*k +: 4], 1'b0);
      send(5, d5, 1'b0);
      send(6, d6, 1'b0);
      send(7, d7, 1'b1);
   endtask

   initial begin
      rst_n   = 1'b0;
      scan_en = 1'b0;
      scan_in = 16'hFFFF;
      repeat (3) @(negedge clk_fs);
      chk("rst_value", 32'(value_out), 32'h0);
      chk("rst_valid", 32'(value_valid), 32'h0);
      chk("rst_dp", 32'(dp_out), 32'h0);
      chk("rst_code", 32'(sw_code), 32'h0);
      chk("rst_swerr", 32'(sw_err), 32'h0);
      chk("rst_ferr", 32'(frame_err), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      rst_n = 1'b1;

      send_frame(20'h12345, 4'h6, 4'h9, 4'h3, 0);
      chk("f1_vv", 32'(vv), 32'd0);
      chk("f1_locked", 32'(locked), 32'd1);
      send_frame(20'h12345, 4'h6, 4'h9, 4'h3, 0);
      chk("f2_vv", 32'(vv), 32'd1);
      chk("f2_value", 32'(value_out), 32'h12345);
      chk("f2_code", 32'(sw_code), 32'd3);
      chk("f2_swerr", 32'(sw_err), 32'd0);
      chk("f2_dp", 32'(dp_out), 32'h80);

      send_frame(20'h9ACE0, 4'h0, 4'h8, 4'h1, 1);
      chk("f3_vv", 32'(vv), 32'd2);
      send_frame(20'h76543, 4'h4, 4'h2, 4'h5, 1);
      chk("dbl_vv", 32'(vv), 32'd3);
      chk("dbl_fe", 32'(fe), 32'd0);
      chk("f3_value", 32'(value_out), 32'h9ACE0);
      chk("f3_code", 32'(sw_code), 32'd0);

      send(0, 4'h3, 1'b0);
      send(1, 4'h4, 1'b0);
      send(2, 4'h5, 1'b0);
      send(4, 4'h7, 1'b0);
      chk("skip_vv", 32'(vv), 32'd4);
      chk("skip_fe", 32'(fe), 32'd1);
      chk("skip_locked", 32'(locked), 32'd0);
      chk("skip_value", 32'(value_out), 32'h76543);
      chk("skip_code", 32'(sw_code), 32'd4);

      send_frame(20'h11111, 4'h0, 4'h5, 4'h8, 0);
      chk("f5_locked", 32'(locked), 32'd1);
      bad_idx = 2;
      send_frame(20'h22222, 4'h0, 4'h3, 4'h3, 0);
      bad_idx = -1;
      chk("f5_vv", 32'(vv), 32'd5);
      chk("f5_value", 32'(value_out), 32'h11111);
      chk("f5_code", 32'(sw_code), 32'd7);
      send_frame(20'h33333, 4'h3, 4'h4, 4'h7, 0);
      chk("glyph_fe", 32'(fe), 32'd2);
      chk("glyph_vv", 32'(vv), 32'd5);
      chk("glyph_value", 32'(value_out), 32'h11111);

      send_frame(20'h44444, 4'h1, 4'h1, 4'h1, 0);
      chk("f7_value", 32'(value_out), 32'h33333);
      chk("f7_code", 32'(sw_code), 32'd6);
      send_frame(20'h55555, 4'h0, 4'h8, 4'h1, 0);
      chk("nomode_vv", 32'(vv), 32'd7);
      chk("nomode_value", 32'(value_out), 32'h44444);
      chk("nomode_swerr", 32'(sw_err), 32'd1);
      chk("nomode_code", 32'(sw_code), 32'd6);

      send(0, 4'h6, 1'b0);
      for (int k = 1; k < 5; k++)
         send(k, 4'h6, 1'b0);
      chk("f9_vv", 32'(vv), 32'd8);
      chk("f9_swerr", 32'(sw_err), 32'd0);
      chk("f9_code", 32'(sw_code), 32'd0);
      @(negedge clk_fs);
      rst_n = 1'b0;
      #1;
      chk("mrst_value", 32'(value_out), 32'h0);
      chk("mrst_dp", 32'(dp_out), 32'h0);
      chk("mrst_code", 32'(sw_code), 32'h0);
      chk("mrst_locked", 32'(locked), 32'h0);
      @(negedge clk_fs);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_fs);
      chk("mrst_valid", 32'(value_valid), 32'h0);
      chk("mrst_ferr", 32'(frame_err), 32'h0);
      send_frame(20'h66666, 4'h6, 4'h9, 4'h3, 0);
      chk("post_vv", 32'(vv), 32'd8);
      chk("post_fe", 32'(fe), 32'd2);
      send(0, 4'h6, 1'b0);
      chk("post_commit_vv", 32'(vv), 32'd9);
      chk("post_value", 32'(value_out), 32'h66666);
      chk("post_code", 32'(sw_code), 32'd3);

      $display("Result: errors=%0d of %0d checks",
               n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/led_scan_decoder.md
LED_SCAN_DECODER -- requirements
Module: led_scan_decoder

Interface
REQ-001 Parameters: none; all code tables are fixed constants in the shared package.
REQ-002 clk_fs  in  1  system clock; all logic rises on posedge clk_fs.
REQ-003 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-004 scan_en  in  1  sample strobe, one clk_fs cycle wide, asserted once per scan-bus update.
REQ-005 scan_in  in  16  multiplexed display bus; [15:8] digit select (active-low one-hot), [7:0] segments (active-low, bit7 = dp).
REQ-006 value_out  out  20  reassembled hex value; digit k supplies nibble [4k+3:4k] for k = 0..4.
REQ-007 value_valid  out  1  one-cycle pulse when value_out, dp_out and sw_code update.
REQ-008 dp_out  out  8  per-digit decimal point of the last committed frame; 1 = lit.
REQ-009 sw_code  out  3  mode code recovered from digits 5..7.
REQ-010 sw_err  out  1  level; last committed frame held no valid mode triple.
REQ-011 frame_err  out  1  one-cycle pulse when a frame is discarded.
REQ-012 locked  out  1  level; FSM is in COLLECT.

Function
REQ-013 Samples act only on cycles with scan_en=1; scan_in is ignored on all other cycles.
REQ-014 Select decode: FE,FD,FB,F7,EF,DF,BF,7F map to index 0..7; any other value is a select error.
REQ-015 Glyph decode on segments[6:0]: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 46->C, 06->E, 0E->F; any other value is a glyph error with nibble 0.
REQ-016 dp = ~segments[7], taken independently of the glyph.
REQ-017 FSM states are HUNT and COLLECT; reset enters HUNT.
REQ-018 In HUNT, a valid sample with index 0 stores digit 0, clears the frame error flag and moves to COLLECT; all other samples are discarded.
REQ-019 In COLLECT, an index equal to the previous index is a repeat: overwrite the digit, stay in COLLECT.
REQ-020 In COLLECT, an index equal to previous+1 stores the digit and stays in COLLECT.
REQ-021 In COLLECT, index 0 after index 7 commits the frame, then starts a new frame with digit 0 in COLLECT.
REQ-022 In COLLECT, any other index or a select error: frame_err pulse, go to HUNT, no commit.
REQ-023 A glyph error in COLLECT sets a sticky frame flag; at the commit point a flagged frame pulses frame_err instead of value_valid, and outputs keep their previous values.
REQ-024 Commit: value_out, dp_out, sw_code and sw_err update and value_valid pulses in the cycle after the committing sample (latency 1 clk_fs).
REQ-025 Mode triple (digit7, digit6, digit5) maps to sw_code: 1.80->0, 2.61->1, 3.30->2, 3.96->3, 5.24->4, 6.18->5, 7.43->6, 8.50->7.
REQ-026 For the mode triple, digit7 must carry dp=1 and digits 6 and 5 must carry dp=0.
REQ-027 No mode-triple match: sw_err=1 and sw_code holds its previous value; the value is still committed.
REQ-028 An index repeated any number of times (e.g. a double display of digit 0 at scan wrap) raises no error.

Reset
REQ-029 On rst_n=0: value_out=0, dp_out=0, sw_code=0, sw_err=0, value_valid=0, frame_err=0, locked=0, digit store cleared, FSM in HUNT.
REQ-030 Reset asserted mid-frame discards the partial frame; no pulse is emitted on release.

Structure
REQ-031 Shared package holds the select-code table, glyph table, mode-triple table and the FSM state type.
REQ-032 Sub-module seg7_glyph_decode holds the combinational glyph decode (segments -> nibble, dp, glyph error).

Verification
REQ-033 Scan 0x12345, mode 3 (digits 5..7 = 6, 9, 3, dp on digit7), two full frames -> value_out=0x12345, sw_code=3, one value_valid per frame from the second index 0 on.
REQ-034 Sequence with digit 0 sent twice at each wrap (0,1..7,0,0,1..) -> no frame_err, commits continue.
REQ-035 Index 3 skipped (0,1,2,4) -> frame_err pulse, locked=0, outputs unchanged; next clean frame commits.
REQ-036 Segment byte 0xFF on digit 2 -> frame_err at commit; value_out keeps its old value.
REQ-037 Digits 5..7 = 1, 1, 1 -> value_valid pulse, sw_err=1, sw_code unchanged.
REQ-038 rst_n pulsed low after index 4 -> all outputs 0, HUNT; no pulse until a full new frame completes.
